// File: rtl/s_to_p_if.sv
// s_to_p_if -- bundle for the serial-to-parallel receiver.
// The master side is the serialiser and the consumer together: it drives the
// bit stream, the frame enable and the read acknowledge. The slave side is the
// receiver: it returns the assembled byte and its status flags.
//   Dbit_in    serial data, MSB first, valid while link_S_in=1
//   link_S_in  bit-valid / frame enable
//   rd_ack     consumer acknowledge, clears data_valid
//   data_out   last complete byte
//   data_valid a byte is held in data_out and has not been read
//   frame_err  one-cycle pulse, frame truncated
//   overrun    one-cycle pulse, an unread byte was overwritten
interface s_to_p_if;
  logic       Dbit_in;
  logic       link_S_in;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output Dbit_in, link_S_in, rd_ack,
    input  data_out, data_valid, frame_err, overrun
  );

  modport slave (
    input  Dbit_in, link_S_in, rd_ack,
    output data_out, data_valid, frame_err, overrun
  );
endinterface

// File: rtl/s_to_p.sv
// s_to_p -- serial-to-parallel byte receiver.
// Samples Dbit_in MSB first on every rising clk edge with link_S_in=1 and
// presents each completed byte on data_out with a data_valid level that the
// consumer clears with rd_ack. A frame that drops link_S_in mid-byte is
// discarded with a frame_err pulse; a byte completing over an unread one
// raises an overrun pulse.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   bus      s_to_p_if slave modport (serial input, byte output, status)
//   byte_cnt 8-bit wrapping count of completed bytes; exists only when the
//            macro S_TO_P_BYTE_CNT_EN is defined
module s_to_p (
  input  logic       clk,
  input  logic       rst,
  s_to_p_if.slave    bus
`ifdef S_TO_P_BYTE_CNT_EN
  , output logic [7:0] byte_cnt
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t     state_q,   state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q,   shift_d;
  logic [7:0] data_q,    data_d;
  logic       valid_q,   valid_d;
  logic       ferr_q,    ferr_d;
  logic       ovr_q,     ovr_d;
  logic       done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    done      = 1'b0;

    if (bus.link_S_in) begin
      shift_d   = {shift_q[5:0], bus.Dbit_in};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        // eighth bit: byte complete, counter wraps to 0 so the next sampled
        // bit starts a fresh byte with no gap
        done    = 1'b1;
        data_d  = {shift_q, bus.Dbit_in};
        state_d = IDLE;
      end else begin
        state_d = SHIFT;
      end
    end else if (state_q == SHIFT) begin
      ferr_d    = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
      state_d   = IDLE;
    end

    // a completing byte takes precedence over a coincident acknowledge
    if (done) begin
      valid_d = 1'b1;
      ovr_d   = valid_q & ~bus.rd_ack;
    end else if (bus.rd_ack) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

`ifdef S_TO_P_BYTE_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (done) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign byte_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_s_to_p.sv
// tb_s_to_p -- directed self-checking bench for s_to_p.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_s_to_p;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  s_to_p_if bus ();

`ifdef S_TO_P_BYTE_CNT_EN
  logic [7:0] byte_cnt;
`endif

  s_to_p dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef S_TO_P_BYTE_CNT_EN
    , .byte_cnt (byte_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one edge with link_S_in=1 carrying bit b, optional rd_ack on the same edge
  task automatic send_bit(input logic b, input logic ack);
    bus.Dbit_in   = b;
    bus.link_S_in = 1'b1;
    bus.rd_ack    = ack;
    @(posedge clk);
    #1;
    bus.rd_ack    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack_last);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], (i == 0) ? ack_last : 1'b0);
    end
  endtask

  // one edge with link_S_in=0
  task automatic idle(input logic ack);
    bus.link_S_in = 1'b0;
    bus.Dbit_in   = 1'b0;
    bus.rd_ack    = ack;
    @(posedge clk);
    #1;
    bus.rd_ack    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.link_S_in = 1'b1;
    bus.Dbit_in   = 1'b1;
    bus.rd_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", bus.data_out);
    end
    checks++;
    if (bus.data_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid);
    end
    checks++;
    if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got ferr=%b ovr=%b exp 0 0", bus.frame_err, bus.overrun);
    end
    rst = 1'b0;
    bus.link_S_in = 1'b0;
    idle(1'b0);
  endtask

  task automatic test_single_byte();
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    checks++;
    if (bus.data_valid !== 1'b0) begin
      failures++; $display("FAIL single_early_valid got=%b exp=0", bus.data_valid);
    end
    send_bit(v[0], 1'b0);
    checks++;
    if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_byte got data=%h valid=%b exp A5 1", bus.data_out, bus.data_valid);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL single_ferr got=%b exp=0", bus.frame_err);
    end
    idle(1'b1);
    checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
      failures++;
      $display("FAIL single_ack got data=%h valid=%b exp A5 0", bus.data_out, bus.data_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    send_byte(8'h3C, 1'b0);
    checks++;
    if (bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got data=%h valid=%b exp 3C 1", bus.data_out, bus.data_valid);
    end
    v = 8'hC3;
    send_bit(v[7], 1'b1);
    checks++;
    if (bus.data_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_ack got valid=%b exp=0", bus.data_valid);
    end
    for (int i = 6; i >= 0; i--) send_bit(v[i], 1'b0);
    checks++;
    if (bus.data_out !== 8'hC3 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got data=%h valid=%b ovr=%b exp C3 1 0",
               bus.data_out, bus.data_valid, bus.overrun);
    end
    idle(1'b0);
  endtask

  // entered with C3 held and unread
  task automatic test_truncation();
    logic [7:0] v;
    v = 8'hFF;
    for (int i = 0; i < 5; i++) send_bit(v[i], 1'b0);
    idle(1'b0);
    checks++;
    if (bus.frame_err !== 1'b1) begin
      failures++; $display("FAIL trunc_ferr got=%b exp=1", bus.frame_err);
    end
    checks++;
    if (bus.data_out !== 8'hC3 || bus.data_valid !== 1'b1) begin
      failures++;
      $display("FAIL trunc_hold got data=%h valid=%b exp C3 1", bus.data_out, bus.data_valid);
    end
    idle(1'b1);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL trunc_pulse_len got=%b exp=0", bus.frame_err);
    end
    send_byte(8'h81, 1'b0);
    checks++;
    if (bus.data_out !== 8'h81 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL trunc_next got data=%h valid=%b ovr=%b exp 81 1 0",
               bus.data_out, bus.data_valid, bus.overrun);
    end
    idle(1'b1);
  endtask

  task automatic test_overrun();
    send_byte(8'h11, 1'b0);
    checks++;
    if (bus.data_out !== 8'h11 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first got data=%h ovr=%b exp 11 0", bus.data_out, bus.overrun);
    end
    send_byte(8'h22, 1'b0);
    checks++;
    if (bus.data_out !== 8'h22 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second got data=%h valid=%b ovr=%b exp 22 1 1",
               bus.data_out, bus.data_valid, bus.overrun);
    end
    idle(1'b0);
    checks++;
    if (bus.overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_pulse_len got=%b exp=0", bus.overrun);
    end
    send_byte(8'h33, 1'b1);
    checks++;
    if (bus.data_out !== 8'h33 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_ack_race got data=%h valid=%b ovr=%b exp 33 1 0",
               bus.data_out, bus.data_valid, bus.overrun);
    end
    idle(1'b0);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] v;
    v = 8'hAF;
    for (int i = 7; i >= 4; i--) send_bit(v[i], 1'b0);
    rst = 1'b1;
    idle(1'b0);
    checks++;
    if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got data=%h valid=%b ferr=%b ovr=%b exp 00 0 0 0",
               bus.data_out, bus.data_valid, bus.frame_err, bus.overrun);
    end
    rst = 1'b0;
    idle(1'b0);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL rstmid_ferr got=%b exp=0", bus.frame_err);
    end
    send_byte(8'hF0, 1'b0);
    checks++;
    if (bus.data_out !== 8'hF0 || bus.data_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_next got data=%h valid=%b exp F0 1", bus.data_out, bus.data_valid);
    end
    idle(1'b1);
  endtask

`ifdef S_TO_P_BYTE_CNT_EN
  task automatic test_byte_cnt();
    logic [7:0] v;
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    checks++;
    if (byte_cnt !== 8'h00) begin
      failures++; $display("FAIL cnt_reset got=%h exp=00", byte_cnt);
    end
    for (int n = 0; n < 257; n++) begin
      v = n[7:0];
      send_byte(v ^ 8'h5A, 1'b0);
    end
    checks++;
    if (byte_cnt !== 8'h01 || bus.data_out !== 8'h5A) begin
      failures++;
      $display("FAIL cnt_257 got cnt=%h data=%h exp 01 5A", byte_cnt, bus.data_out);
    end
    v = 8'hFF;
    for (int i = 0; i < 3; i++) send_bit(v[i], 1'b0);
    idle(1'b0);
    checks++;
    if (byte_cnt !== 8'h01 || bus.frame_err !== 1'b1) begin
      failures++;
      $display("FAIL cnt_trunc got cnt=%h ferr=%b exp 01 1", byte_cnt, bus.frame_err);
    end
    idle(1'b1);
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.Dbit_in   = 1'b0;
    bus.link_S_in = 1'b0;
    bus.rd_ack    = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_truncation();
    test_overrun();
    test_reset_mid_byte();
`ifdef S_TO_P_BYTE_CNT_EN
    test_byte_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
